addsub_serial: RTL

- Parametrised, digit-serial adder/subtractor; multi-cycle successor to the 8-bit combinational subtractor.
- Processes DIGIT bits per clock over WIDTH/DIGIT cycles, using a start/busy/done handshake.
- Supports add and subtract (two's complement) modes and reports carry, signed overflow and zero flags.
- Used in area-constrained datapaths where a full-width carry chain is not affordable.

---
 rtl/addsub_serial_if.sv | 32 +++
 rtl/addsub_serial.sv | 112 +++++++++++
 2 files changed

// File: rtl/addsub_serial_if.sv
// Request/result bundle for the digit-serial adder/subtractor.
//
// Handshake: the master raises start with mode/a/b/ci valid; the request is
// taken on the first rising edge where start=1 and busy=0 (busy is the
// inverse of ready). Operands are only sampled on that edge. done pulses for
// exactly one cycle when s/co/ov/zf hold the new result; those outputs then
// stay stable until the next completion.
interface addsub_serial_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             mode;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             ci;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] s;
  logic             co;
  logic             ov;
  logic             zf;

  modport master (
    output start, mode, a, b, ci,
    input  busy, done, s, co, ov, zf
  );

  modport slave (
    input  start, mode, a, b, ci,
    output busy, done, s, co, ov, zf
  );
endinterface

// File: rtl/addsub_serial.sv
// Digit-serial two's-complement adder/subtractor. Consumes DIGIT bits of each
// operand per cycle, LSB first, and completes in WIDTH/DIGIT RUN cycles.
// Subtraction is done as a + ~b + ci, so ci=1 / co=1 mean "no borrow".
module addsub_serial #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  addsub_serial_if.slave bus,
  output logic           dbg_state_o
);
  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] opa_q;
  logic [WIDTH-1:0] opb_q;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] s_q;
  logic [CW-1:0]    cnt_q;
  logic             carry_q;
  logic             msba_q;
  logic             msbb_q;
  logic             busy_q;
  logic             done_q;
  logic             co_q;
  logic             ov_q;
  logic             zf_q;

  logic [DIGIT:0]         sum_d;
  logic [WIDTH+DIGIT-1:0] cat_d;
  logic [WIDTH-1:0]       acc_d;
  logic                   last_d;

  // One digit slice of the ripple adder plus the result shift-in. The new
  // digit enters at the top so after N shifts the LSB digit sits at bit 0.
  always_comb begin
    sum_d  = {1'b0, opa_q[DIGIT-1:0]} + {1'b0, opb_q[DIGIT-1:0]}
           + {{DIGIT{1'b0}}, carry_q};
    cat_d  = {sum_d[DIGIT-1:0], acc_q};
    acc_d  = cat_d[WIDTH+DIGIT-1:DIGIT];
    last_d = (cnt_q == CW'(N - 1));
  end

  // Control FSM and datapath registers; all outputs are registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      opa_q   <= '0;
      opb_q   <= '0;
      acc_q   <= '0;
      s_q     <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      msba_q  <= 1'b0;
      msbb_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      co_q    <= 1'b0;
      ov_q    <= 1'b0;
      zf_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            opa_q   <= bus.a;
            opb_q   <= bus.mode ? ~bus.b : bus.b;
            carry_q <= bus.ci;
            cnt_q   <= '0;
            msba_q  <= bus.a[WIDTH-1];
            msbb_q  <= bus.mode ? ~bus.b[WIDTH-1] : bus.b[WIDTH-1];
            busy_q  <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          acc_q   <= acc_d;
          opa_q   <= opa_q >> DIGIT;
          opb_q   <= opb_q >> DIGIT;
          carry_q <= sum_d[DIGIT];
          cnt_q   <= cnt_q + CW'(1);
          if (last_d) begin
            s_q     <= acc_d;
            co_q    <= sum_d[DIGIT];
            // Overflow: operands share a sign the result does not.
            ov_q    <= (msba_q == msbb_q) && (acc_d[WIDTH-1] != msba_q);
            zf_q    <= (acc_d == '0);
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.s       = s_q;
  assign bus.co      = co_q;
  assign bus.ov      = ov_q;
  assign bus.zf      = zf_q;
  assign dbg_state_o = state_q;
endmodule
